// File: rtl/vector_comparison_pkg.sv
// Shared types and helpers for the multi-beat vector integer comparison unit.
// Element compare works on 65-bit extended operands so one comparator covers signed and unsigned ops.
package vector_comparison_pkg;

  typedef enum logic [2:0] {
    CMP_EQ, CMP_NE, CMP_LTU, CMP_LT, CMP_LEU, CMP_LE, CMP_GTU, CMP_GT
  } cmp_op_t;

  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} sew_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} cmp_state_t;

  function automatic int unsigned sew_bits(sew_t s);
    return 32'd8 << s;
  endfunction

  function automatic logic cmp_is_signed(cmp_op_t op);
    return (op == CMP_LT) || (op == CMP_LE) || (op == CMP_GT);
  endfunction

  // Operands arrive already sign- or zero-extended to 65 bits.
  function automatic logic cmp_elem(logic [64:0] a, logic [64:0] b, cmp_op_t op);
    logic eq;
    logic lt;
    logic r;
    eq = (a == b);
    lt = $signed(a) < $signed(b);
    case (op)
      CMP_EQ:            r = eq;
      CMP_NE:            r = !eq;
      CMP_LTU, CMP_LT:   r = lt;
      CMP_LEU, CMP_LE:   r = lt | eq;
      CMP_GTU, CMP_GT:   r = !(lt | eq);
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_compare_beat.sv
// Combinational compare of one DATAPATH_WIDTH slice; mask bits for the selected SEW
// are packed at the low end, unused upper bits read as zero.
module vector_compare_beat
  import vector_comparison_pkg::*;
#(
  parameter int DATAPATH_WIDTH = 64
) (
  input  logic [DATAPATH_WIDTH-1:0]   a,
  input  logic [DATAPATH_WIDTH-1:0]   b,
  input  cmp_op_t                     op,
  input  sew_t                        sew,
  output logic [DATAPATH_WIDTH/8-1:0] mask
);

  localparam int MB = DATAPATH_WIDTH / 8;

  logic            is_signed;
  logic [3:0][MB-1:0] res;

  assign is_signed = cmp_is_signed(op);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sew
    localparam int W   = 8 << gi;
    localparam int NEL = DATAPATH_WIDTH / W;
    for (genvar gj = 0; gj < MB; gj++) begin : g_el
      if (gj < NEL) begin : g_act
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        assign ea = a[gj*W +: W];
        assign eb = b[gj*W +: W];
        assign res[gi][gj] = cmp_elem({{(65-W){is_signed & ea[W-1]}}, ea},
                                      {{(65-W){is_signed & eb[W-1]}}, eb}, op);
      end else begin : g_pad
        assign res[gi][gj] = 1'b0;
      end
    end
  end

  assign mask = res[sew];

endmodule

// File: rtl/vector_comparison_unit_multicycle.sv
// Multi-beat RVV integer compare: walks vs2/vs1 one DATAPATH_WIDTH slice per cycle and
// merges results into a mask-undisturbed copy of vd_old.
module vector_comparison_unit_multicycle
  import vector_comparison_pkg::*;
#(
  parameter int VLEN           = 128,
  parameter int DATAPATH_WIDTH = 64,
  parameter int ELEN           = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  cmp_op_t         op,
  input  sew_t            sew,
  input  logic [31:0]     vl,
  input  logic            vm,
  input  logic            use_scalar,
  input  logic [ELEN-1:0] scalar,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] v0,
  input  logic [VLEN-1:0] vd_old,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] vd,
  output logic            busy
);

  localparam int MB        = DATAPATH_WIDTH / 8;
  localparam int BEATS_MAX = VLEN / DATAPATH_WIDTH;
  localparam int BW        = $clog2(BEATS_MAX + 1);

  cmp_state_t      state_reg, state_next;
  cmp_op_t         op_reg;
  sew_t            sew_reg;
  logic            use_scalar_reg;
  logic [ELEN-1:0] scalar_reg;
  logic [VLEN-1:0] vs2_reg, vs1_reg, active_reg, vd_reg, vd_out_reg;
  logic [BW-1:0]   beat_reg, beats_reg;

  logic [31:0]     vlmax_in, vl_eff_in;
  logic [BW-1:0]   beats_in;
  logic [VLEN-1:0] active_in;
  logic            last_beat;

  // Element activity is resolved once at accept time so EXEC only needs a bit mask.
  always_comb begin
    vlmax_in  = 32'(VLEN) / sew_bits(sew);
    vl_eff_in = (vl < vlmax_in) ? vl : vlmax_in;
    beats_in  = BW'((vl_eff_in * sew_bits(sew) + 32'(DATAPATH_WIDTH - 1)) / 32'(DATAPATH_WIDTH));
    active_in = '0;
    for (int j = 0; j < VLEN; j++)
      active_in[j] = (32'(j) < vl_eff_in) && (vm || v0[j]);
  end

  assign last_beat = (beat_reg == beats_reg - 1'b1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = (beats_in == '0) ? DONE : EXEC;
      end
      EXEC: if (last_beat) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [3:0][DATAPATH_WIDTH-1:0] scalar_rep;
  logic [DATAPATH_WIDTH-1:0]      b_slice;
  logic [MB-1:0]                  beat_mask;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rep
    localparam int W = 8 << gi;
    assign scalar_rep[gi] = {(DATAPATH_WIDTH / W){scalar_reg[W-1:0]}};
  end

  // Operand registers shift down each beat, so the current slice is always the low bits.
  assign b_slice = use_scalar_reg ? scalar_rep[sew_reg] : vs1_reg[DATAPATH_WIDTH-1:0];

  vector_compare_beat #(.DATAPATH_WIDTH(DATAPATH_WIDTH)) u_beat (
    .a    (vs2_reg[DATAPATH_WIDTH-1:0]),
    .b    (b_slice),
    .op   (op_reg),
    .sew  (sew_reg),
    .mask (beat_mask)
  );

  logic [3:0][VLEN-1:0] hit, bit_res;
  logic [VLEN-1:0]      upd, vd_merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_map
    localparam int W   = 8 << gi;
    localparam int EPB = DATAPATH_WIDTH / W;
    for (genvar gj = 0; gj < VLEN; gj++) begin : g_bit
      if (gj < VLEN / W) begin : g_el
        assign hit[gi][gj]     = (beat_reg == BW'(gj / EPB));
        assign bit_res[gi][gj] = beat_mask[gj % EPB];
      end else begin : g_tail
        assign hit[gi][gj]     = 1'b0;
        assign bit_res[gi][gj] = 1'b0;
      end
    end
  end

  assign upd       = hit[sew_reg] & active_reg;
  assign vd_merged = (vd_reg & ~upd) | (bit_res[sew_reg] & upd);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_reg         <= CMP_EQ;
      sew_reg        <= SEW8;
      use_scalar_reg <= 1'b0;
      scalar_reg     <= '0;
      vs2_reg        <= '0;
      vs1_reg        <= '0;
      active_reg     <= '0;
      vd_reg         <= '0;
      vd_out_reg     <= '0;
      beat_reg       <= '0;
      beats_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          op_reg         <= op;
          sew_reg        <= sew;
          use_scalar_reg <= use_scalar;
          scalar_reg     <= scalar;
          vs2_reg        <= vs2;
          vs1_reg        <= vs1;
          active_reg     <= active_in;
          vd_reg         <= vd_old;
          beats_reg      <= beats_in;
          beat_reg       <= '0;
          if (beats_in == '0) vd_out_reg <= vd_old;
        end
        EXEC: begin
          vs2_reg  <= vs2_reg >> DATAPATH_WIDTH;
          vs1_reg  <= vs1_reg >> DATAPATH_WIDTH;
          vd_reg   <= vd_merged;
          beat_reg <= beat_reg + 1'b1;
          if (last_beat) vd_out_reg <= vd_merged;
        end
        default: ;
      endcase
    end
  end

  assign vd = vd_out_reg;

endmodule
